output_stationary_bus_arbiter: RTL and testbench
================================================

# output_stationary_bus_arbiter

Parametrised round-robin arbiter for the output-stationary result bus shared by `NUM_CORES` PE cores. Each grant runs one burst: an add phase (partial sums from the core into the accumulation buffer) or an unload phase (final results out), alternating per core. It generates the beat index, the read/write direction and the add/unload enables. Beats stall on a downstream ready handshake, and each transaction ends with a done pulse.

## Interface
Parameters:
- `NUM_CORES`, default `OUT_ARB_NUM_CORES` (4): number of requesting cores, ≥2.
- `BURST_W`, default 6: width of burst length and beat address.
- `IDX_W`, default `$clog2(NUM_CORES)`: width of `grant_idx`.

Ports:
- `w_clock`  in  1  sole clock, rising edge.
- `w_reset_n`  in  1  asynchronous, active-low reset.
- `w_clear`  in  1  synchronous soft clear; priority over all other behaviour except reset.
- `w_req`  in  NUM_CORES  level request per core; core holds it until it sees `done` with its grant.
- `w_add_len`  in  BURST_W  beat count for an add-phase burst; sampled at grant.
- `w_unload_len`  in  BURST_W  beat count for an unload-phase burst; sampled at grant.
- `w_bus_ready`  in  1  downstream accepts the current beat.
- `grant`  out  NUM_CORES  one-hot grant, all zero when idle.
- `grant_idx`  out  IDX_W  binary index of the granted core.
- `burst`  out  BURST_W  latched length of the current burst.
- `add_en`  out  1  current burst is an add phase.
- `unload_en`  out  1  current burst is an unload phase.
- `rw`  out  1  direction: 0 = write/add, 1 = read/unload.
- `beat_valid`  out  1  a beat is presented this cycle.
- `addr`  out  BURST_W  beat index within the burst, starting at 0.
- `done`  out  1  one-cycle end-of-transaction pulse.

## Operation
- State: `r_phase[NUM_CORES]` (0 = add next, 1 = unload next), round-robin pointer `r_ptr` (IDX_W), beat counter `r_count` (BURST_W).
- FSM states:
  - IDLE: grant 0, no beat. If `w_req != 0`, select the first set bit at index ≥ `r_ptr`, wrapping to index 0. Register `grant`, `grant_idx`, `add_en = ~r_phase[sel]`, `unload_en = rw = r_phase[sel]`, and `burst` from `w_add_len` or `w_unload_len` by that phase. Clear `r_count`. Go to XFER, or to DONE when the selected length is 0.
  - XFER: `beat_valid = 1`, `addr = r_count`.
    - Handshake: a beat completes on a cycle with `beat_valid && w_bus_ready`; then `r_count` increments.
    - `w_bus_ready` low: `addr` and `beat_valid` hold (stall, no limit).
    - Completion of beat `burst-1`: go to DONE.
  - DONE: `beat_valid = 0`, `done = 1`. `grant`, `grant_idx`, `burst`, `add_en`, `unload_en` and `rw` hold their values. Toggle `r_phase[grant_idx]`, set `r_ptr = grant_idx+1` (mod NUM_CORES), go to IDLE.
- `w_req` changes during XFER/DONE are ignored. A granted core dropping its request mid-burst does not abort the burst.
- `w_len` inputs are ignored after sampling.
- `w_clear` high, any state: go to IDLE, all outputs to reset values, `r_phase` and `r_ptr` cleared. No `done` pulse; an aborted burst is lost.
- Every output is always driven; no high-impedance values.

## Timing
- Reset (async assert, sync release): state IDLE, `r_ptr` 0, `r_phase` all 0. All outputs 0: `grant`, `grant_idx`, `burst`, `add_en`, `unload_en`, `rw`, `beat_valid`, `addr`, `done`.
- Reset asserted mid-burst: outputs go to 0 immediately, without waiting for a clock edge.
- Request seen at an IDLE edge: grant and first beat valid on the next cycle.
- Burst of length L with `w_bus_ready` held high:
  - Beats occupy L cycles, with `addr` 0..L-1.
  - DONE follows for 1 cycle, then IDLE for 1 cycle.
  - One transaction takes L+2 cycles; back-to-back grants are separated by exactly one IDLE cycle.
- Length 0: IDLE → DONE, no beats; the phase still toggles.
- Length field `2^BURST_W-1` is the maximum; `r_count` never wraps within a burst.
- `done` is registered, asserted exactly one cycle per completed transaction.

## Test plan
- Reset then single request, NUM_CORES=4: `w_req=0010`, add_len=3, bus_ready=1 → `grant=0010`, `grant_idx=1`, `add_en=1`, `rw=0`; `addr` 0,1,2 over 3 cycles; `done` next cycle. Core re-requests with unload_len=2 → `unload_en=1`, `rw=1`, 2 beats.
- Round-robin: `w_req=1111` held, lengths 1 → grant order 0001, 0010, 0100, 1000, 0001, with each core's phase alternating add/unload on successive grants.
- Stall: len=4, `w_bus_ready` low for 3 cycles during beat 1 → `addr` holds at 1 and `beat_valid` stays 1; the total transaction is 3 cycles longer; `done` fires once.
- Zero length: add_len=0 → grant for one DONE cycle, `beat_valid` never 1, `done=1`; the next grant to that core is unload.
- Mid-burst `w_clear` on beat 2 of 5 → next cycle all outputs 0, no `done`; the next grant starts at core 0 with an add phase.
- Async `w_reset_n` low between clock edges during XFER → outputs 0 immediately. After release, arbitration restarts from core 0.

Source files
------------

// File: rtl/output_stationary_bus_arbiter.sv
// Round-robin owner of the shared result bus: one add or unload burst per grant, phase alternating per core.
// Grant and first beat one cycle after the IDLE sample; beats hold on w_bus_ready low indefinitely.
`ifndef OUT_ARB_NUM_CORES
`define OUT_ARB_NUM_CORES 4
`endif

module output_stationary_bus_arbiter #(
  parameter int NUM_CORES = `OUT_ARB_NUM_CORES,
  parameter int BURST_W   = 6,
  parameter int IDX_W     = $clog2(NUM_CORES)
) (
  input  logic                 w_clock,
  input  logic                 w_reset_n,
  input  logic                 w_clear,
  input  logic [NUM_CORES-1:0] w_req,
  input  logic [BURST_W-1:0]   w_add_len,
  input  logic [BURST_W-1:0]   w_unload_len,
  input  logic                 w_bus_ready,
  output logic [NUM_CORES-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic [BURST_W-1:0]   burst,
  output logic                 add_en,
  output logic                 unload_en,
  output logic                 rw,
  output logic                 beat_valid,
  output logic [BURST_W-1:0]   addr,
  output logic                 done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [NUM_CORES-1:0] phase_q, phase_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [BURST_W-1:0]   count_q, count_d;
  logic [NUM_CORES-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic                 add_en_q, add_en_d;
  logic                 unload_en_q, unload_en_d;
  logic                 done_q, done_d;

  logic [IDX_W-1:0]     sel;
  logic                 sel_vld;
  int                   j;

  // Scan downward so the requester closest at or after the pointer wins last.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    j       = 0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_CORES) j = j - NUM_CORES;
      if (w_req[j]) begin
        sel     = IDX_W'(j);
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    burst_d     = burst_q;
    add_en_d    = add_en_q;
    unload_en_d = unload_en_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_vld) begin
          grant_d     = NUM_CORES'(1) << sel;
          grant_idx_d = sel;
          add_en_d    = ~phase_q[sel];
          unload_en_d = phase_q[sel];
          burst_d     = phase_q[sel] ? w_unload_len : w_add_len;
          count_d     = '0;
          if (burst_d == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_XFER;
          end
        end
      end
      ST_XFER: begin
        if (w_bus_ready) begin
          count_d = count_q + BURST_W'(1);
          if (count_q == burst_q - BURST_W'(1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        phase_d[grant_idx_q] = ~phase_q[grant_idx_q];
        ptr_d       = (grant_idx_q == IDX_W'(NUM_CORES - 1)) ? '0 : grant_idx_q + IDX_W'(1);
        grant_d     = '0;
        grant_idx_d = '0;
        burst_d     = '0;
        add_en_d    = 1'b0;
        unload_en_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Soft clear drops any burst in flight without a done pulse.
    if (w_clear) begin
      state_d     = ST_IDLE;
      phase_d     = '0;
      ptr_d       = '0;
      count_d     = '0;
      grant_d     = '0;
      grant_idx_d = '0;
      burst_d     = '0;
      add_en_d    = 1'b0;
      unload_en_d = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      ptr_q       <= '0;
      count_q     <= '0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      burst_q     <= '0;
      add_en_q    <= 1'b0;
      unload_en_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      burst_q     <= burst_d;
      add_en_q    <= add_en_d;
      unload_en_q <= unload_en_d;
      done_q      <= done_d;
    end
  end

  assign grant      = grant_q;
  assign grant_idx  = grant_idx_q;
  assign burst      = burst_q;
  assign add_en     = add_en_q;
  assign unload_en  = unload_en_q;
  assign rw         = unload_en_q;
  assign beat_valid = (state_q == ST_XFER);
  assign addr       = beat_valid ? count_q : '0;
  assign done       = done_q;

endmodule

// File: tb/tb_output_stationary_bus_arbiter.sv
// Scoreboard bench: stimulus predicts each transaction from a round-robin/phase model and queues it;
// a negedge monitor pops and checks grant fields, beat addresses, stall timing and the done pulse.
module tb_output_stationary_bus_arbiter;
  localparam int NC = 4;
  localparam int BW = 6;

  logic          w_clock = 1'b0;
  logic          w_reset_n, w_clear, w_bus_ready;
  logic [NC-1:0] w_req;
  logic [BW-1:0] w_add_len, w_unload_len;
  logic [NC-1:0] grant;
  logic [1:0]    grant_idx;
  logic [BW-1:0] burst, addr;
  logic          add_en, unload_en, rw, beat_valid, done;

  output_stationary_bus_arbiter #(.NUM_CORES(NC), .BURST_W(BW)) dut (
    .w_clock(w_clock), .w_reset_n(w_reset_n), .w_clear(w_clear), .w_req(w_req),
    .w_add_len(w_add_len), .w_unload_len(w_unload_len), .w_bus_ready(w_bus_ready),
    .grant(grant), .grant_idx(grant_idx), .burst(burst), .add_en(add_en),
    .unload_en(unload_en), .rw(rw), .beat_valid(beat_valid), .addr(addr), .done(done)
  );

  always #5 w_clock = ~w_clock;

  typedef struct {
    int idx;
    bit unl;
    int len;
    int stl;
    bit gap;
  } exp_t;

  exp_t expq[$];
  exp_t cur;
  int   errors = 0, checks = 0;
  int   cyc = 0, last_done = -100, abort_exp = 0, abort_seen = 0;
  int   ready_mode = 0, stall_addr = 1, stall_left = 0;
  int   m_ptr;
  bit   m_phase[NC];
  bit   b2b;
  bit   active, prev_done;
  int   beats, stalls, start;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  task automatic finish_up();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic zeros_chk(input string pfx);
    chk({pfx, "_grant"}, 32'(grant), 0);
    chk({pfx, "_grant_idx"}, 32'(grant_idx), 0);
    chk({pfx, "_burst"}, 32'(burst), 0);
    chk({pfx, "_add_en"}, 32'(add_en), 0);
    chk({pfx, "_unload_en"}, 32'(unload_en), 0);
    chk({pfx, "_rw"}, 32'(rw), 0);
    chk({pfx, "_beat_valid"}, 32'(beat_valid), 0);
    chk({pfx, "_addr"}, 32'(addr), 0);
    chk({pfx, "_done"}, 32'(done), 0);
  endtask

  function automatic void model_reset();
    m_ptr = 0;
    for (int i = 0; i < NC; i++) m_phase[i] = 1'b0;
  endfunction

  // Reference: first requester at or after the pointer, phase alternates per core.
  task automatic push_req(input logic [NC-1:0] mask, input int alen, input int ulen, input int stl);
    exp_t e;
    int   s;
    s = -1;
    for (int i = 0; i < NC; i++)
      if (s < 0 && mask[(m_ptr + i) % NC]) s = (m_ptr + i) % NC;
    w_req        = mask;
    w_add_len    = BW'(alen);
    w_unload_len = BW'(ulen);
    e.idx = s;
    e.unl = m_phase[s];
    e.len = m_phase[s] ? ulen : alen;
    e.stl = stl;
    e.gap = b2b;
    expq.push_back(e);
    m_phase[s] = ~m_phase[s];
    m_ptr      = (s + 1) % NC;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge w_clock);
      n++;
    end while (!done && n < 400);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_done: no done pulse within %0d cycles", n);
      finish_up();
    end
    b2b = 1'b1;
  endtask

  task automatic wait_beat2();
    int n;
    n = 0;
    do begin
      @(negedge w_clock);
      n++;
    end while (!(beat_valid && addr == BW'(2)) && n < 100);
    if (!(beat_valid && addr == BW'(2))) begin
      checks++;
      errors++;
      $display("FAIL wait_beat2: beat 2 never presented within %0d cycles", n);
      finish_up();
    end
  endtask

  // Ready driver: random, or high except for a scheduled stall at one beat address.
  initial begin
    w_bus_ready = 1'b1;
    forever begin
      @(posedge w_clock);
      #1;
      if (ready_mode == 1) w_bus_ready = ($urandom_range(0, 3) != 0);
      else if (stall_left > 0 && beat_valid && addr == BW'(stall_addr)) begin
        w_bus_ready = 1'b0;
        stall_left--;
      end else w_bus_ready = 1'b1;
    end
  end

  // Monitor
  initial begin
    active    = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge w_clock);
      cyc++;
      if (!active && grant != '0) begin
        if (expq.size() == 0) begin
          chk("unexpected_grant", 32'(grant), 0);
        end else begin
          active = 1'b1;
          beats  = 0;
          stalls = 0;
          start  = cyc;
          cur    = expq[0];
          chk("grant", 32'(grant), 32'(1 << cur.idx));
          chk("grant_idx", 32'(grant_idx), 32'(cur.idx));
          chk("add_en", 32'(add_en), 32'(!cur.unl));
          chk("unload_en", 32'(unload_en), 32'(cur.unl));
          chk("rw", 32'(rw), 32'(cur.unl));
          chk("burst", 32'(burst), 32'(cur.len));
          chk("first_beat_valid", 32'(beat_valid), 32'(cur.len != 0));
          if (cur.gap) chk("idle_gap", 32'(cyc - last_done), 2);
        end
      end
      if (active) begin
        if (grant == '0 && !done) begin
          chk("abort_expected", 32'(abort_seen < abort_exp), 1);
          abort_seen++;
          void'(expq.pop_front());
          active = 1'b0;
        end else begin
          chk("grant_hold", 32'(grant), 32'(1 << cur.idx));
          if (beat_valid) begin
            chk("addr", 32'(addr), 32'(beats));
            if (w_bus_ready) beats++;
            else stalls++;
          end
          if (done) begin
            chk("done_beats", 32'(beats), 32'(cur.len));
            chk("done_beat_valid", 32'(beat_valid), 0);
            chk("done_rw", 32'(rw), 32'(cur.unl));
            chk("done_burst", 32'(burst), 32'(cur.len));
            chk("xact_cycles", 32'(cyc - start), 32'(cur.len + stalls));
            if (cur.stl >= 0) chk("stall_cycles", 32'(stalls), 32'(cur.stl));
            void'(expq.pop_front());
            active    = 1'b0;
            last_done = cyc;
          end
        end
      end else begin
        chk("idle_quiet", 32'({grant, beat_valid, done}), 0);
      end
      if (done) chk("done_single", 32'(prev_done), 0);
      prev_done = done;
    end
  end

  // Stimulus
  initial begin
    w_reset_n    = 1'b1;
    w_clear      = 1'b0;
    w_req        = '0;
    w_add_len    = '0;
    w_unload_len = '0;
    b2b          = 1'b0;
    model_reset();
    #1 w_reset_n = 1'b0;
    #2;
    zeros_chk("reset");
    repeat (2) @(negedge w_clock);
    w_reset_n = 1'b1;
    @(negedge w_clock);

    // Single core: add then unload
    push_req(4'b0010, 3, 9, 0); wait_done();
    push_req(4'b0010, 7, 2, 0); wait_done();
    // Round robin with all cores requesting
    repeat (5) begin
      push_req(4'b1111, 1, 1, 0);
      wait_done();
    end
    // Stall three cycles on beat 1
    stall_addr = 1;
    stall_left = 3;
    push_req(4'b0001, 4, 4, 3); wait_done();
    // Zero-length burst, then the same core again
    push_req(4'b1000, 0, 0, 0); wait_done();
    push_req(4'b1000, 2, 2, 0); wait_done();
    // Maximum length
    push_req(4'b0100, 63, 63, 0); wait_done();
    // Random masks, lengths and ready
    ready_mode = 1;
    repeat (60) begin
      push_req(NC'($urandom_range(1, 15)), int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), -1);
      wait_done();
    end
    ready_mode = 0;

    // Soft clear on beat 2 of 5
    push_req(4'b0100, 5, 5, -1);
    wait_beat2();
    abort_exp++;
    w_clear = 1'b1;
    w_req   = '0;
    @(negedge w_clock);
    zeros_chk("clear");
    w_clear = 1'b0;
    model_reset();
    b2b = 1'b0;
    push_req(4'b1111, 2, 3, -1); wait_done();

    // Async reset between edges mid-burst
    push_req(4'b0010, 6, 6, -1);
    wait_beat2();
    abort_exp++;
    w_req = '0;
    #2 w_reset_n = 1'b0;
    #1;
    zeros_chk("areset");
    repeat (2) @(negedge w_clock);
    w_reset_n = 1'b1;
    model_reset();
    b2b = 1'b0;
    push_req(4'b1111, 3, 3, -1); wait_done();
    w_req = '0;

    repeat (3) @(negedge w_clock);
    chk("queue_empty", 32'(expq.size()), 0);
    finish_up();
  end

endmodule
